// File: rtl/ram_pkg.sv
// Shared definitions for the RAM stream controller: address-width helper and
// the per-cycle RAM operation encoding.
package ram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } op_t;

  function automatic int clogb2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/ram_stream_ctrl_if.sv
// Stream-in, stream-out and external RAM port bundle of ram_stream_ctrl.
// Handshakes: a word moves when valid && ready on a rising edge; valid never waits on ready.
interface ram_stream_ctrl_if
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256
) ();
  localparam int AW = clogb2(DEPTH);

  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  ram_wren;
  logic [AW-1:0]         ram_address;
  logic [DATA_WIDTH-1:0] ram_data;
  logic [DATA_WIDTH-1:0] ram_q;
  logic [AW:0]           used;
  op_t                   dbg_op;
  op_t                   dbg_last_op;

  modport master (
    input  s_valid, s_data, m_ready, ram_q,
    output s_ready, m_valid, m_data, ram_wren, ram_address, ram_data, used,
           dbg_op, dbg_last_op
  );

  modport slave (
    output s_valid, s_data, m_ready, ram_q,
    input  s_ready, m_valid, m_data, ram_wren, ram_address, ram_data, used,
           dbg_op, dbg_last_op
  );
endinterface

// File: rtl/ram_stream_obuf.sv
// Two-entry output buffer that captures RAM read data and presents it downstream.
module ram_stream_obuf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] data,
  output logic [1:0]   count
);
  logic [W-1:0] mem [2];
  logic         head;
  logic         wr_idx;

  // With two entries the tail slot is the head flipped by the low count bit.
  assign wr_idx = head ^ count[0];
  assign data   = mem[head];

  always_ff @(posedge clk) begin
    if (push) mem[wr_idx] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (pop) head <= ~head;
      count <= count + 2'(push) - 2'(pop);
    end
  end
endmodule

// File: rtl/ram_stream_ctrl.sv
// Runs an external single-port RAM as a circular FIFO between two valid/ready streams,
// alternating writes and reads when both directions are pending.
module ram_stream_ctrl
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic              clk,
  input  logic              rst,
  ram_stream_ctrl_if.master bus
);
  localparam int          AW     = clogb2(DEPTH);
  localparam logic [AW:0] FULL_W = (AW+1)'(DEPTH);

  logic [AW:0] wr_ptr, rd_ptr, used_w;
  logic        rd_inflight;
  logic        rd_elig;
  logic [1:0]  ob_cnt;
  op_t         last_op, last_op_nxt, op;

  assign used_w  = wr_ptr - rd_ptr;
  assign rd_elig = (used_w != '0) && ((ob_cnt + {1'b0, rd_inflight}) < 2'd2);

  // A pending read after a write blocks the input for one cycle, forcing alternation.
  assign bus.s_ready = !rst && (used_w != FULL_W) && !(rd_elig && last_op == WRITE);

  always_comb begin
    op          = IDLE;
    last_op_nxt = last_op;
    if (!rst) begin
      if (bus.s_valid && bus.s_ready) op = WRITE;
      else if (rd_elig)               op = READ;
    end
    if (op != IDLE) last_op_nxt = op;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rd_inflight <= 1'b0;
      last_op     <= READ;
    end else begin
      last_op     <= last_op_nxt;
      rd_inflight <= (op == READ);
      if (op == WRITE) wr_ptr <= wr_ptr + 1'b1;
      if (op == READ)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign bus.ram_wren    = (op == WRITE);
  assign bus.ram_address = (op == WRITE) ? wr_ptr[AW-1:0] : rd_ptr[AW-1:0];
  assign bus.ram_data    = bus.s_data;
  assign bus.used        = used_w;
  assign bus.m_valid     = (ob_cnt != 2'd0);
  assign bus.dbg_op      = op;
  assign bus.dbg_last_op = last_op;

  ram_stream_obuf #(.W(DATA_WIDTH)) u_obuf (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_inflight),
    .push_data (bus.ram_q),
    .pop       (bus.m_valid && bus.m_ready),
    .data      (bus.m_data),
    .count     (ob_cnt)
  );
endmodule

// File: tb/tb_ram_stream_ctrl.sv
// Self-checking bench for ram_stream_ctrl with an external RAM model and a
// queue-based scoreboard of accepted words.
module tb_ram_stream_ctrl;
  import ram_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 256;
  localparam int AW    = clogb2(DEPTH);

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_stream_ctrl_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  ram_stream_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // external RAM: registered read, one cycle latency
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.ram_wren) mem[bus.ram_address] <= bus.ram_data;
    bus.ram_q <= mem[bus.ram_address];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard
  logic [DW-1:0] exp_q[$];
  int            wr_count;
  bit            wrapped;
  bit            stall_prev;
  logic [DW-1:0] stall_data;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      wr_count   = 0;
      stall_prev = 1'b0;
    end else begin
      check("wren_vs_handshake", 32'(bus.ram_wren), 32'(bus.s_valid && bus.s_ready));
      if (bus.ram_wren) begin
        check("wr_addr", 32'(bus.ram_address), 32'(wr_count % DEPTH));
        check("wr_data", 32'(bus.ram_data), 32'(bus.s_data));
        if (bus.ram_address == '0 && wr_count > 0) wrapped = 1'b1;
        wr_count++;
      end
      if (bus.s_valid && bus.s_ready) exp_q.push_back(bus.s_data);
      if (stall_prev) begin
        check("stall_valid", 32'(bus.m_valid), 32'd1);
        check("stall_data", 32'(bus.m_data), 32'(stall_data));
      end
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) check("unexpected_output", 32'(bus.m_data), 32'hFFFF_FFFF);
        else check("out_order", 32'(bus.m_data), 32'(exp_q.pop_front()));
      end
      stall_prev = bus.m_valid && !bus.m_ready;
      stall_data = bus.m_data;
    end
  end

  // driver state
  logic [DW-1:0] cur_data;
  bit            inc_mode;
  bit            snap_acc, snap_wren, snap_mv;
  logic [AW-1:0] snap_addr;
  logic [AW:0]   snap_used;

  // One clock: called and returns at posedge+1, samples DUT at the negedge.
  task automatic cycle(input bit v, input bit r);
    bus.s_valid = v;
    bus.m_ready = r;
    bus.s_data  = cur_data;
    @(negedge clk);
    snap_acc  = v && bus.s_ready;
    snap_wren = bus.ram_wren;
    snap_addr = bus.ram_address;
    snap_used = bus.used;
    snap_mv   = bus.m_valid;
    if (snap_acc) cur_data = inc_mode ? cur_data + 1'b1 : DW'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_used", 32'(bus.used), 32'd0);
    check("rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("rst_s_ready", 32'(bus.s_ready), 32'd0);
    check("rst_wren", 32'(bus.ram_wren), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run(input int max_words, input int vpct, input int rpct,
                     input int max_cycles, output int sent);
    bit pend;
    bit v, r;
    pend = 1'b0;
    sent = 0;
    for (int c = 0; c < max_cycles && sent < max_words; c++) begin
      v = pend || ($urandom_range(0, 99) < vpct);
      r = ($urandom_range(0, 99) < rpct);
      cycle(v, r);
      pend = v && !snap_acc;
      if (snap_acc) sent++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
  endtask

  task automatic drain(input string name, input int bound);
    bit done;
    done = 1'b0;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    for (int i = 0; i < bound && !done; i++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && !bus.m_valid;
      @(posedge clk);
      #1;
    end
    check({name, "_drain_done"}, 32'(done), 32'd1);
    check({name, "_drain_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  typedef struct {
    int          n_words;
    logic [AW:0] exp_used;
    logic        exp_mvalid;
  } vec_t;

  vec_t          vecs[6];
  logic [DW-1:0] t1_words[3];
  int            sent;
  int            k;
  int            lat;
  bit            prev_wren;

  initial begin
    // words held back by a stalled sink: two sit in the buffer, the rest in RAM
    vecs[0] = '{0, 9'd0, 1'b0};
    vecs[1] = '{1, 9'd0, 1'b1};
    vecs[2] = '{2, 9'd0, 1'b1};
    vecs[3] = '{3, 9'd1, 1'b1};
    vecs[4] = '{5, 9'd3, 1'b1};
    vecs[5] = '{10, 9'd8, 1'b1};
    t1_words[0] = 8'h11;
    t1_words[1] = 8'h22;
    t1_words[2] = 8'h33;

    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    bus.s_data  = '0;
    inc_mode    = 1'b0;
    cur_data    = DW'($urandom);
    wrapped     = 1'b0;

    // table-driven occupancy vectors
    foreach (vecs[i]) begin
      do_reset();
      run(vecs[i].n_words, 100, 0, 100, sent);
      check("tbl_sent", 32'(sent), 32'(vecs[i].n_words));
      idle(6);
      check("tbl_used", 32'(snap_used), 32'(vecs[i].exp_used));
      check("tbl_m_valid", 32'(snap_mv), 32'(vecs[i].exp_mvalid));
      drain("tbl", 100);
    end

    // Test 1: three known words, stalled sink, then drain in order
    do_reset();
    k = 0;
    for (int c = 0; c < 20 && k < 3; c++) begin
      cur_data = t1_words[k];
      cycle(1'b1, 1'b0);
      if (snap_acc) begin
        check("t1_wren", 32'(snap_wren), 32'd1);
        check("t1_addr", 32'(snap_addr), 32'(k));
        k++;
      end
    end
    check("t1_count", 32'(k), 32'd3);
    drain("t1", 50);

    // latency from acceptance to m_valid on an empty controller
    do_reset();
    cycle(1'b1, 1'b0);
    check("lat_accept", 32'(snap_acc), 32'd1);
    lat = -1;
    for (int i = 1; i <= 8 && lat < 0; i++) begin
      cycle(1'b0, 1'b0);
      if (snap_mv) lat = i;
    end
    check("latency", 32'(lat), 32'd3);
    drain("lat", 50);

    // Test 2: fill to full with sink stalled
    do_reset();
    run(1000, 100, 0, 400, sent);
    check("t2_accepted", 32'(sent), 32'd258);
    cycle(1'b1, 1'b0);
    check("t2_s_ready", 32'(snap_acc), 32'd0);
    check("t2_used", 32'(snap_used), 32'(DEPTH));
    drain("t2", 2000);

    // Test 3: 600 incrementing words through a free-running sink
    do_reset();
    inc_mode = 1'b1;
    cur_data = '0;
    wrapped  = 1'b0;
    run(600, 100, 100, 5000, sent);
    check("t3_sent", 32'(sent), 32'd600);
    drain("t3", 1000);
    check("t3_wrapped", 32'(wrapped), 32'd1);
    inc_mode = 1'b0;

    // Test 4: saturated both sides with used=10 -> strict alternation
    do_reset();
    run(12, 100, 0, 200, sent);
    idle(6);
    check("t4_pre_used", 32'(snap_used), 32'd10);
    prev_wren = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b1);
      check("t4_used_range", 32'(snap_used >= 10 && snap_used <= 11), 32'd1);
      if (i > 0) check("t4_alternate", 32'(snap_wren), 32'(!prev_wren));
      prev_wren = snap_wren;
    end
    drain("t4", 200);

    // Test 5: random valid/ready over 2000 words
    do_reset();
    run(2000, 70, 60, 20000, sent);
    check("t5_sent", 32'(sent), 32'd2000);
    drain("t5", 2000);

    // Test 6: reset with used=5 and a read in flight
    do_reset();
    run(8, 100, 0, 100, sent);
    idle(6);
    check("t6_pre_used6", 32'(snap_used), 32'd6);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    check("t6_pre_used5", 32'(bus.used), 32'd5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle(1'b0, 1'b0);
    check("t6_used", 32'(snap_used), 32'd0);
    check("t6_m_valid", 32'(snap_mv), 32'd0);
    check("t6_wren", 32'(snap_wren), 32'd0);
    cycle(1'b0, 1'b0);
    check("t6_no_stale_push", 32'(snap_mv), 32'd0);
    cycle(1'b1, 1'b0);
    check("t6_accept", 32'(snap_acc), 32'd1);
    check("t6_addr0", 32'(snap_addr), 32'd0);
    drain("t6", 50);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
